// File: rtl/tick_counter.sv
// tick_counter: prescaled clock-enable tick generator driving a modulo-MOD
// up/down counter. It has a synchronous load, a terminal-count pulse and a
// divided square-wave output. Everything runs on the single clk domain.
//
// Build option: define TICK_COUNTER_SAT_EN to make the counter saturate at
// its bounds instead of wrapping. tc then pulses on every tick where the
// step was blocked at a bound.
module tick_counter #(
    parameter int WIDTH     = 4,
    parameter int MOD       = 16,
    parameter int DIV_WIDTH = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     count,
    output logic                 tick,
    output logic                 tc,
    output logic                 div_out
);

    // Largest legal count value. When MOD == 2**WIDTH this is all-ones, so
    // the explicit wrap below matches natural overflow.
    localparam logic [WIDTH-1:0]     CNT_MAX = WIDTH'(MOD - 1);
    // The modulus is held one bit wider so that MOD == 2**WIDTH is
    // representable for the load clamp compare.
    localparam logic [WIDTH:0]       MOD_EXT = (WIDTH + 1)'(MOD);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] pre_cnt;
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] pre_last;
    logic                 wrap;
    logic [WIDTH-1:0]     count_step;
    logic                 tc_step;
    logic [WIDTH-1:0]     load_clamped;

    // Effective period, prescaler wrap detect and clamped load value.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        period       = (div_val == '0) ? DIV_ONE : div_val;
        pre_last     = period - DIV_ONE;
        // The >= compare also catches a pre_cnt left above a newly lowered
        // period, so it wraps on the next edge instead of running to 2**DIV_WIDTH.
        wrap         = en && !load && (pre_cnt >= pre_last);
        load_clamped = ({1'b0, load_val} >= MOD_EXT) ? CNT_MAX : load_val;
    end

    // Next counter value and terminal-count flag for a wrap edge.
    always_comb begin
        count_step = count;
        tc_step    = 1'b0;
        if (up_dn) begin
            if (count == CNT_MAX) begin
`ifdef TICK_COUNTER_SAT_EN
                count_step = CNT_MAX;
`else
                count_step = '0;
`endif
                tc_step    = 1'b1;
            end else begin
                count_step = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
`ifdef TICK_COUNTER_SAT_EN
                count_step = '0;
`else
                count_step = CNT_MAX;
`endif
                tc_step    = 1'b1;
            end else begin
                count_step = count - WIDTH'(1);
            end
        end
    end

    // Prescaler. A load restarts it, en=0 freezes it, and a wrap returns it to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= wrap ? '0 : pre_cnt + DIV_ONE;
        end
    end

    // Counter and registered outputs. Load has priority, then the wrap step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            tick    <= 1'b0;
            tc      <= 1'b0;
            div_out <= 1'b0;
        end else if (load) begin
            count   <= load_clamped;
            tick    <= 1'b0;
            tc      <= 1'b0;
        end else if (wrap) begin
            count   <= count_step;
            tick    <= 1'b1;
            tc      <= tc_step;
            div_out <= ~div_out;
        end else begin
            tick    <= 1'b0;
            tc      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_counter.sv
// Testbench for tick_counter. It drives two instances from the same inputs:
// u_a with MOD=10 (clamped, explicit wrap) and u_f with MOD=16 (natural overflow).
// Directed scenarios use hand-derived constants. The random phase compares
// against an integer reference model built from the behavioural rules.
module tb_tick_counter;

    localparam int DW = 22;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] div_val;
    logic          up_dn;
    logic          load;
    logic [3:0]    load_val;
    logic [3:0]    count_a, count_f;
    logic          tick_a, tick_f, tc_a, tc_f, dout_a, dout_f;

    int n_checks = 0;
    int n_fail   = 0;

    tick_counter #(.WIDTH(4), .MOD(10), .DIV_WIDTH(DW)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .up_dn(up_dn),
        .load(load), .load_val(load_val), .count(count_a), .tick(tick_a),
        .tc(tc_a), .div_out(dout_a)
    );

    tick_counter #(.WIDTH(4), .MOD(16), .DIV_WIDTH(DW)) u_f (
        .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .up_dn(up_dn),
        .load(load), .load_val(load_val), .count(count_f), .tick(tick_f),
        .tc(tc_f), .div_out(dout_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // 'phase' counts clk edges since the last wrap or load.
    typedef struct {
        int phase;
        int cnt;
        bit tick;
        bit tc;
        bit dout;
    } model_t;

    model_t m_a, m_f;

    function automatic model_t model_next(model_t s, int mod, bit e, int dv, bit up, bit ld, int lv);
        model_t n;
        int p;
        n = s;
        p = (dv == 0) ? 1 : dv;
        n.tick = 0;
        n.tc   = 0;
        if (ld) begin
            n.cnt   = (lv >= mod) ? mod - 1 : lv;
            n.phase = 0;
        end else if (e) begin
            if (s.phase + 1 >= p) begin
                n.phase = 0;
                n.tick  = 1;
                n.dout  = !s.dout;
`ifdef TICK_COUNTER_SAT_EN
                if (up) begin
                    if (s.cnt == mod - 1) n.tc = 1; else n.cnt = s.cnt + 1;
                end else begin
                    if (s.cnt == 0) n.tc = 1; else n.cnt = s.cnt - 1;
                end
`else
                if (up) begin
                    n.cnt = (s.cnt + 1) % mod;
                    n.tc  = (n.cnt == 0);
                end else begin
                    n.cnt = (s.cnt + mod - 1) % mod;
                    n.tc  = (s.cnt == 0);
                end
`endif
            end else begin
                n.phase = s.phase + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '{default: 0};
            m_f <= '{default: 0};
        end else begin
            m_a <= model_next(m_a, 10, en, int'(div_val), up_dn, load, int'(load_val));
            m_f <= model_next(m_f, 16, en, int'(div_val), up_dn, load, int'(load_val));
        end
    end

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; div_val = DW'(4); up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({count_a, tick_a, tc_a, dout_a} !== 7'd0) begin n_fail++; $display("FAIL reset_init count=%0d tick=%b tc=%b div_out=%b exp all 0", count_a, tick_a, tc_a, dout_a); end
        rst_n = 1'b1;
        load = 1'b1; load_val = 4'd7;
        step();
        load = 1'b0; en = 1'b1;
        step(); step();
        n_checks++; if (count_a !== 4'd7) begin n_fail++; $display("FAIL reset_pre_count count=%0d exp=7", count_a); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({count_a, tick_a, tc_a, dout_a} !== 7'd0) begin n_fail++; $display("FAIL reset_async count=%0d tick=%b tc=%b div_out=%b exp all 0", count_a, tick_a, tc_a, dout_a); end
        n_checks++; if ({count_f, tick_f, tc_f, dout_f} !== 7'd0) begin n_fail++; $display("FAIL reset_async_f count=%0d tick=%b exp all 0", count_f, tick_f); end
        #2 rst_n = 1'b1;
        en = 1'b1; div_val = DW'(4);
        repeat (3) step();
        n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL reset_no_early_tick tick=%b exp=0", tick_a); end
        step();
        n_checks++; if (tick_a !== 1'b1 || count_a !== 4'd1) begin n_fail++; $display("FAIL reset_first_tick tick=%b count=%0d exp tick=1 count=1", tick_a, count_a); end
    endtask

    task automatic test_up_wrap();
        bit d0;
        div_val = DW'(3); up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd8;
        step();
        load = 1'b0;
        d0 = m_a.dout;
        n_checks++; if (count_a !== 4'd8 || tick_a !== 1'b0) begin n_fail++; $display("FAIL up_load count=%0d tick=%b exp count=8 tick=0", count_a, tick_a); end
        step(); step();
        n_checks++; if (count_a !== 4'd8 || tick_a !== 1'b0) begin n_fail++; $display("FAIL up_wait count=%0d tick=%b exp count=8 tick=0", count_a, tick_a); end
        step();
        n_checks++; if (count_a !== 4'd9 || tick_a !== 1'b1 || tc_a !== 1'b0) begin n_fail++; $display("FAIL up_step9 count=%0d tick=%b tc=%b exp 9/1/0", count_a, tick_a, tc_a); end
        n_checks++; if (dout_a !== !d0) begin n_fail++; $display("FAIL up_divout_toggle div_out=%b exp=%b", dout_a, !d0); end
        step();
        n_checks++; if (tick_a !== 1'b0 || tc_a !== 1'b0) begin n_fail++; $display("FAIL up_pulse_width tick=%b tc=%b exp 0/0", tick_a, tc_a); end
        step(); step();
        n_checks++; if (count_a !== 4'd0 || tick_a !== 1'b1 || tc_a !== 1'b1) begin n_fail++; $display("FAIL up_wrap count=%0d tick=%b tc=%b exp 0/1/1", count_a, tick_a, tc_a); end
        n_checks++; if (dout_a !== d0) begin n_fail++; $display("FAIL up_divout_period div_out=%b exp=%b", dout_a, d0); end
        n_checks++; if (count_f !== 4'd10 || tc_f !== 1'b0) begin n_fail++; $display("FAIL up_full count=%0d tc=%b exp 10/0", count_f, tc_f); end
        step();
        n_checks++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL up_tc_width tc=%b exp=0", tc_a); end
    endtask

    task automatic test_down_wrap();
        div_val = DW'(2); up_dn = 1'b0; load = 1'b1; load_val = 4'd1;
        step();
        load = 1'b0;
        n_checks++; if (count_a !== 4'd1) begin n_fail++; $display("FAIL dn_load count=%0d exp=1", count_a); end
        step(); step();
        n_checks++; if (count_a !== 4'd0 || tc_a !== 1'b0 || tick_a !== 1'b1) begin n_fail++; $display("FAIL dn_step0 count=%0d tc=%b tick=%b exp 0/0/1", count_a, tc_a, tick_a); end
        step(); step();
        n_checks++; if (count_a !== 4'd9 || tc_a !== 1'b1) begin n_fail++; $display("FAIL dn_wrap count=%0d tc=%b exp 9/1", count_a, tc_a); end
        n_checks++; if (count_f !== 4'd15 || tc_f !== 1'b1) begin n_fail++; $display("FAIL dn_wrap_full count=%0d tc=%b exp 15/1", count_f, tc_f); end
        up_dn = 1'b1;
        step();
        n_checks++; if (tick_a !== 1'b0 || count_a !== 4'd9) begin n_fail++; $display("FAIL dir_hold tick=%b count=%0d exp 0/9", tick_a, count_a); end
        step();
        n_checks++; if (count_a !== 4'd0 || tc_a !== 1'b1) begin n_fail++; $display("FAIL dir_change count=%0d tc=%b exp 0/1", count_a, tc_a); end
        n_checks++; if (count_f !== 4'd0 || tc_f !== 1'b1) begin n_fail++; $display("FAIL dir_change_full count=%0d tc=%b exp 0/1", count_f, tc_f); end
    endtask

    task automatic test_enable_edges();
        bit dexp;
        div_val = DW'(0); up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            n_checks++; if (tick_a !== 1'b1 || count_a !== 4'(i % 10) || tc_a !== (i % 10 == 0)) begin n_fail++; $display("FAIL p1_cycle%0d tick=%b count=%0d tc=%b exp tick=1 count=%0d", i, tick_a, count_a, tc_a, i % 10); end
        end
        dexp = m_a.dout;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (count_a !== 4'd2 || tick_a !== 1'b0 || tc_a !== 1'b0 || dout_a !== dexp) begin n_fail++; $display("FAIL en_freeze%0d count=%0d tick=%b tc=%b div_out=%b exp 2/0/0/%b", i, count_a, tick_a, tc_a, dout_a, dexp); end
        end
        en = 1'b1; div_val = DW'(100); load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        repeat (50) step();
        n_checks++; if (tick_a !== 1'b0 || count_a !== 4'd0) begin n_fail++; $display("FAIL div100_wait tick=%b count=%0d exp 0/0", tick_a, count_a); end
        div_val = DW'(2);
        step();
        n_checks++; if (tick_a !== 1'b1 || count_a !== 4'd1) begin n_fail++; $display("FAIL div_lowered tick=%b count=%0d exp 1/1", tick_a, count_a); end
    endtask

    task automatic test_load_priority();
        bit dexp;
        div_val = DW'(3); up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        step(); step();
        dexp = m_a.dout;
        load = 1'b1; load_val = 4'd15;
        step();
        load = 1'b0;
        n_checks++; if (count_a !== 4'd9 || tick_a !== 1'b0 || tc_a !== 1'b0) begin n_fail++; $display("FAIL load_clamp count=%0d tick=%b tc=%b exp 9/0/0", count_a, tick_a, tc_a); end
        n_checks++; if (count_f !== 4'd15 || dout_a !== dexp) begin n_fail++; $display("FAIL load_full count=%0d div_out=%b exp 15/%b", count_f, dout_a, dexp); end
        step(); step();
        n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL load_restart tick=%b exp=0", tick_a); end
        step();
        n_checks++; if (tick_a !== 1'b1 || count_a !== 4'd0 || tc_a !== 1'b1) begin n_fail++; $display("FAIL load_next_tick tick=%b count=%0d tc=%b exp 1/0/1", tick_a, count_a, tc_a); end
        n_checks++; if (count_f !== 4'd0 || tc_f !== 1'b1) begin n_fail++; $display("FAIL full_overflow count=%0d tc=%b exp 0/1", count_f, tc_f); end
    endtask

    task automatic test_sat();
        div_val = DW'(2); up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd8;
        step();
        load = 1'b0;
        step(); step();
        n_checks++; if (count_a !== 4'd9 || tc_a !== 1'b0) begin n_fail++; $display("FAIL sat_reach_top count=%0d tc=%b exp 9/0", count_a, tc_a); end
        for (int i = 0; i < 2; i++) begin
            step(); step();
            n_checks++; if (count_a !== 4'd9 || tc_a !== 1'b1 || tick_a !== 1'b1) begin n_fail++; $display("FAIL sat_hold_top%0d count=%0d tc=%b tick=%b exp 9/1/1", i, count_a, tc_a, tick_a); end
        end
        up_dn = 1'b0; load = 1'b1; load_val = 4'd1;
        step();
        load = 1'b0;
        step(); step();
        n_checks++; if (count_a !== 4'd0 || tc_a !== 1'b0) begin n_fail++; $display("FAIL sat_reach_bottom count=%0d tc=%b exp 0/0", count_a, tc_a); end
        step(); step();
        n_checks++; if (count_a !== 4'd0 || tc_a !== 1'b1) begin n_fail++; $display("FAIL sat_hold_bottom count=%0d tc=%b exp 0/1", count_a, tc_a); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = 4'($urandom_range(0, 15));
            up_dn    = ($urandom_range(0, 3) != 0) ? up_dn : !up_dn;
            if ($urandom_range(0, 9) == 0) div_val = DW'($urandom_range(0, 6));
            step();
            n_checks++; if (int'(count_a) !== m_a.cnt || tick_a !== m_a.tick || tc_a !== m_a.tc || dout_a !== m_a.dout) begin
                n_fail++; $display("FAIL rand_a cyc=%0d count=%0d tick=%b tc=%b div_out=%b exp %0d/%b/%b/%b", i, count_a, tick_a, tc_a, dout_a, m_a.cnt, m_a.tick, m_a.tc, m_a.dout);
            end
            n_checks++; if (int'(count_f) !== m_f.cnt || tick_f !== m_f.tick || tc_f !== m_f.tc || dout_f !== m_f.dout) begin
                n_fail++; $display("FAIL rand_f cyc=%0d count=%0d tick=%b tc=%b div_out=%b exp %0d/%b/%b/%b", i, count_f, tick_f, tc_f, dout_f, m_f.cnt, m_f.tick, m_f.tc, m_f.dout);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef TICK_COUNTER_SAT_EN
        test_sat();
`else
        test_up_wrap();
        test_down_wrap();
        test_enable_edges();
        test_load_priority();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
- Parametrised successor to the simple divider/counter block.
- Generates a clock-enable tick from the system clock using a runtime-programmable prescaler. No derived clock is used; everything runs in the single `clk` domain.
- Drives a modulo-N up/down counter with synchronous load, terminal-count pulse and a divided square-wave output.
- Sits between the board clock and display/LED logic. Used wherever a slow event rate (e.g. 1 Hz from 4 MHz) is needed.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 16, counter modulus; count range 0..MOD-1; legal range 2 <= MOD <= 2^WIDTH.
- DIV_WIDTH, 22, width of the prescaler and `div_val`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; when low, prescaler and counter freeze.
- div_val  in  DIV_WIDTH  prescaler period in clk cycles; 0 is treated as 1.
- up_dn  in  1  1 = count up, 0 = count down; sampled on tick edges.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  counter value.
- tick  out  1  registered 1-cycle pulse, one per prescaler wrap.
- tc  out  1  registered 1-cycle terminal-count pulse.
- div_out  out  1  square wave; toggles on each prescaler wrap, so period = 2*div_val cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): `pre_cnt`=0, `count`=0, `tick`=0, `tc`=0, `div_out`=0. Reset mid-operation clears immediately with no pending tick.
- Effective period P = max(div_val,1).
- Prescaler, per edge with en=1 and load=0:
  - if pre_cnt >= P-1: pre_cnt<=0, "wrap" occurs;
  - else pre_cnt<=pre_cnt+1.
  - The >= compare means that lowering div_val mid-run wraps on the next edge; there is never a 2^DIV_WIDTH runaway.
- On a wrap edge (all in the same edge):
  - tick<=1;
  - div_out toggles;
  - count steps: up: MOD-1 -> 0, else +1; down: 0 -> MOD-1, else -1;
  - tc<=1 on the step that wraps the count.
  - Resulting timing: count changes in the same edge that raises tick. tick and tc are high for exactly the following cycle.
- Non-wrap edges: tick<=0, tc<=0.
- P=1: tick stays high continuously while en=1; count steps every cycle.
- en=0: pre_cnt, count and div_out hold; tick<=0, tc<=0. Re-enabling resumes from the held pre_cnt, so there is no phase reset.
- load=1 (priority over everything except reset, and acts regardless of en):
  - count<=load_val, clamped to MOD-1 if load_val >= MOD;
  - pre_cnt<=0;
  - tick<=0, tc<=0;
  - div_out unchanged.
  - A load coinciding with a wrap suppresses that wrap.
- up_dn changes take effect on the next wrap. Each wrap uses the up_dn value sampled at that edge.
- Arithmetic:
  - count is modulo MOD and never exceeds MOD-1.
  - The pre_cnt compare is unsigned DIV_WIDTH.
  - When MOD=2^WIDTH, natural overflow must be equivalent.

Optional Feature:
- Macro: TICK_COUNTER_SAT_EN.
- Without the macro: wrap-around as above.
- With the macro: saturating mode.
  - Up at MOD-1 holds at MOD-1; down at 0 holds at 0.
  - tc pulses on every wrap edge where the step was blocked at the bound.
  - tc does not pulse on the edge that first reaches the bound.
  - tick and div_out behave unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-count (count=7, pre_cnt=2) asynchronously between edges -> all outputs 0 immediately. After release with div_val=4, en=1: first tick 4 edges later, count=1.
- Up wrap: WIDTH=4, MOD=10, div_val=3, up_dn=1, load 8 -> count goes 8,9,0 at 3-cycle spacing; tc high exactly the cycle after 9->0; div_out period 6 cycles.
- Down wrap and direction change: load 1, up_dn=0, div_val=2 -> 1,0,9 with tc on 0->9. Set up_dn=1 between ticks -> next step 9->0 with tc.
- Enable/div_val edge cases:
  - div_val=0 -> tick continuously high, count +1 each cycle.
  - en=0 for 5 cycles -> count/div_out frozen, tick=0.
  - div_val lowered 100->2 while pre_cnt=50 -> wrap on next edge.
- Load priority: load=1, load_val=15 with MOD=10 on a wrap edge -> count=9, tick=0, tc=0, pre_cnt restarts; next tick after P cycles.
- TICK_COUNTER_SAT_EN defined: MOD=10, count at 8, up -> 9 (no tc), then holds 9 with tc pulse on each subsequent tick. Down from 1 -> 0 then holds with tc.
